// File: rtl/seq_stim_ctrl.sv
// Stimulus sequencer for the 3-bit pattern-detector FSM: resets it, streams an arithmetic symbol
// sequence into it, and counts high samples / rising edges. Optional `abort` input: SEQ_STIM_ABORT_EN.
module seq_stim_ctrl #(
  parameter int LEN_W  = 8,
  parameter int RISE_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        seed,
  input  logic [2:0]        step,
  input  logic [LEN_W-1:0]  len,
  input  logic              det_out,
`ifdef SEQ_STIM_ABORT_EN
  input  logic              abort,
`endif
  output logic [2:0]        det_in,
  output logic              det_reset,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  high_cnt,
  output logic [RISE_W-1:0] rise_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_DUT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [2:0]        seed_q, step_q;
  logic [LEN_W-1:0]  len_q, k_q;
  logic              prev_q;
  logic              accept, sample_en, last_sym;

  assign accept    = (state == S_IDLE) && start;
  assign last_sym  = (k_q == len_q - LEN_W'(1));
  // Sample j is taken in RUN cycle j (j>=1) or DRAIN, so it sees the detector's reply to symbol j-1.
  assign sample_en = ((state == S_RUN) && (k_q != '0)) || (state == S_DRAIN);
  assign det_reset = reset || (state == S_RST_DUT);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = (len == '0) ? S_DONE : S_RST_DUT;
      S_RST_DUT: state_n = S_RUN;
      S_RUN:     if (last_sym) state_n = S_DRAIN;
      S_DRAIN:   state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
`ifdef SEQ_STIM_ABORT_EN
    if (abort && ((state == S_RST_DUT) || (state == S_RUN) || (state == S_DRAIN)))
      state_n = S_DONE;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      seed_q   <= '0;
      step_q   <= '0;
      len_q    <= '0;
      k_q      <= '0;
      prev_q   <= 1'b0;
      det_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      high_cnt <= '0;
      rise_cnt <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == S_RST_DUT) || (state_n == S_RUN) || (state_n == S_DRAIN);
      done  <= (state_n == S_DONE);

      // det_in doubles as the symbol accumulator: loaded with seed on RUN entry, stepped while in RUN.
      if (state_n == S_RUN) begin
        det_in <= (state == S_RUN) ? det_in + step_q : seed_q;
        k_q    <= (state == S_RUN) ? k_q + LEN_W'(1) : '0;
      end else begin
        det_in <= '0;
        k_q    <= '0;
      end

      if (accept) begin
        seed_q   <= seed;
        step_q   <= step;
        len_q    <= len;
        high_cnt <= '0;
        rise_cnt <= '0;
        prev_q   <= 1'b0;
      end else if (sample_en) begin
        if (det_out)
          high_cnt <= high_cnt + LEN_W'(1);
        if (det_out && !prev_q && (rise_cnt != '1))
          rise_cnt <= rise_cnt + RISE_W'(1);
        prev_q <= det_out;
      end
    end
  end

endmodule
